// File: rtl/slug_exec_primitives.sv
// Shared execution primitives of the 4-bit slug CPU: loadable up-counter,
// binary-to-one-hot decoder and a 74181-style ALU with active-high data.
module slug_exec_primitives #(
    parameter int CNT_WIDTH = 16,
    parameter int DEC_WIDTH = 3
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        cnt_ld,
    input  logic                        cnt_inc,
    input  logic [CNT_WIDTH-1:0]        cnt_x,
    output logic [CNT_WIDTH-1:0]        cnt_y,
    input  logic [DEC_WIDTH-1:0]        dec_x,
    output logic [(2**DEC_WIDTH)-1:0]   dec_y,
    input  logic [3:0]                  alu_s,
    input  logic                        alu_m,
    input  logic                        alu_crin,
    input  logic [3:0]                  alu_a,
    input  logic [3:0]                  alu_b,
    output logic [3:0]                  alu_f,
    output logic                        alu_crout,
    output logic                        alu_zero
);

    localparam int DEC_OUT = 2**DEC_WIDTH;
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

    function automatic logic is_zero4(input logic [3:0] v);
        return ~|v;
    endfunction

    logic [CNT_WIDTH-1:0] cnt_r;
    logic [DEC_OUT-1:0]   dec_s;
    logic [3:0]           p_s;
    logic [3:0]           q_s;
    logic [4:0]           sum_s;
    logic [3:0]           logic_f_s;
    logic [3:0]           f_s;
    logic                 crout_s;

    // Counter register: load has priority over increment; wraps silently.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_r <= '0;
        end else if (cnt_ld) begin
            cnt_r <= cnt_x;
        end else if (cnt_inc) begin
            cnt_r <= cnt_r + CNT_ONE;
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign cnt_y = cnt_r;

    // One-hot decode of the binary select.
    always_comb begin
        dec_s        = '0;
        dec_s[dec_x] = 1'b1;
    end

    assign dec_y = dec_s;

    // Arithmetic operand selection: result is P + Q + carry-in.
    always_comb begin
        p_s = alu_a;
        q_s = 4'b0000;
        case (alu_s)
            4'd0:    begin p_s = alu_a;            q_s = 4'b0000;        end
            4'd1:    begin p_s = alu_a | alu_b;    q_s = 4'b0000;        end
            4'd2:    begin p_s = alu_a | ~alu_b;   q_s = 4'b0000;        end
            4'd3:    begin p_s = 4'b0000;          q_s = 4'b1111;        end
            4'd4:    begin p_s = alu_a;            q_s = alu_a & ~alu_b; end
            4'd5:    begin p_s = alu_a | alu_b;    q_s = alu_a & ~alu_b; end
            4'd6:    begin p_s = alu_a;            q_s = ~alu_b;         end
            4'd7:    begin p_s = alu_a & ~alu_b;   q_s = 4'b1111;        end
            4'd8:    begin p_s = alu_a;            q_s = alu_a & alu_b;  end
            4'd9:    begin p_s = alu_a;            q_s = alu_b;          end
            4'd10:   begin p_s = alu_a | ~alu_b;   q_s = alu_a & alu_b;  end
            4'd11:   begin p_s = alu_a & alu_b;    q_s = 4'b1111;        end
            4'd12:   begin p_s = alu_a;            q_s = alu_a;          end
            4'd13:   begin p_s = alu_a | alu_b;    q_s = alu_a;          end
            4'd14:   begin p_s = alu_a | ~alu_b;   q_s = alu_a;          end
            4'd15:   begin p_s = alu_a;            q_s = 4'b1111;        end
            default: begin p_s = 4'b0000;          q_s = 4'b0000;        end
        endcase
        sum_s = {1'b0, p_s} + {1'b0, q_s} + {4'b0000, alu_crin};
    end

    // Logic-mode function table.
    always_comb begin
        logic_f_s = 4'b0000;
        case (alu_s)
            4'd0:    logic_f_s = ~alu_a;
            4'd1:    logic_f_s = ~(alu_a | alu_b);
            4'd2:    logic_f_s = ~alu_a & alu_b;
            4'd3:    logic_f_s = 4'b0000;
            4'd4:    logic_f_s = ~(alu_a & alu_b);
            4'd5:    logic_f_s = ~alu_b;
            4'd6:    logic_f_s = alu_a ^ alu_b;
            4'd7:    logic_f_s = alu_a & ~alu_b;
            4'd8:    logic_f_s = ~alu_a | alu_b;
            4'd9:    logic_f_s = ~(alu_a ^ alu_b);
            4'd10:   logic_f_s = alu_b;
            4'd11:   logic_f_s = alu_a & alu_b;
            4'd12:   logic_f_s = 4'b1111;
            4'd13:   logic_f_s = alu_a | ~alu_b;
            4'd14:   logic_f_s = alu_a | alu_b;
            4'd15:   logic_f_s = alu_a;
            default: logic_f_s = 4'b0000;
        endcase
    end

    // Mode mux; logic mode never produces a carry.
    always_comb begin
        f_s     = 4'b0000;
        crout_s = 1'b0;
        if (alu_m) begin
            f_s     = logic_f_s;
            crout_s = 1'b0;
        end else begin
            f_s     = sum_s[3:0];
            crout_s = sum_s[4];
        end
    end

    assign alu_f     = f_s;
    assign alu_crout = crout_s;
    assign alu_zero  = is_zero4(f_s);

endmodule

// File: tb/tb_slug_exec_primitives.sv
// Directed self-checking bench for slug_exec_primitives: counter (16- and
// 2-bit instances), decoder sweep, ALU directed vectors and an exhaustive table.
module tb_slug_exec_primitives;

    logic        clk = 1'b0;
    logic        rst;
    logic        cnt_ld, cnt_inc;
    logic [15:0] cnt_x, cnt_y;
    logic [2:0]  dec_x;
    logic [7:0]  dec_y;
    logic [3:0]  alu_s, alu_a, alu_b, alu_f;
    logic        alu_m, alu_crin, alu_crout, alu_zero;

    logic        c2_inc;
    logic [1:0]  c2_x, c2_y;
    logic [2:0]  d2_x;
    logic [7:0]  d2_y;
    logic [3:0]  a2_f;
    logic        a2_crout, a2_zero;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    slug_exec_primitives #(.CNT_WIDTH(16), .DEC_WIDTH(3)) dut (
        .clk(clk), .rst(rst), .cnt_ld(cnt_ld), .cnt_inc(cnt_inc),
        .cnt_x(cnt_x), .cnt_y(cnt_y), .dec_x(dec_x), .dec_y(dec_y),
        .alu_s(alu_s), .alu_m(alu_m), .alu_crin(alu_crin), .alu_a(alu_a),
        .alu_b(alu_b), .alu_f(alu_f), .alu_crout(alu_crout), .alu_zero(alu_zero)
    );

    slug_exec_primitives #(.CNT_WIDTH(2), .DEC_WIDTH(3)) dut2 (
        .clk(clk), .rst(rst), .cnt_ld(1'b0), .cnt_inc(c2_inc),
        .cnt_x(c2_x), .cnt_y(c2_y), .dec_x(d2_x), .dec_y(d2_y),
        .alu_s(alu_s), .alu_m(alu_m), .alu_crin(alu_crin), .alu_a(alu_a),
        .alu_b(alu_b), .alu_f(a2_f), .alu_crout(a2_crout), .alu_zero(a2_zero)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] want);
        n_checks++;
        if (obs !== want) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, want);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference ALU returning {crout, zero, f[3:0]}.
    function automatic logic [5:0] alu_ref(input logic [3:0] s, input logic m,
                                           input logic ci, input logic [3:0] a,
                                           input logic [3:0] b);
        logic [3:0] p, q, f;
        int         r;
        logic       co;
        if (m) begin
            case (s)
                4'd0: f = ~a;        4'd1: f = ~(a | b);
                4'd2: f = ~a & b;    4'd3: f = 4'h0;
                4'd4: f = ~(a & b);  4'd5: f = ~b;
                4'd6: f = a ^ b;     4'd7: f = a & ~b;
                4'd8: f = ~a | b;    4'd9: f = ~(a ^ b);
                4'd10: f = b;        4'd11: f = a & b;
                4'd12: f = 4'hF;     4'd13: f = a | ~b;
                4'd14: f = a | b;    default: f = a;
            endcase
            co = 1'b0;
        end else begin
            case (s)
                4'd0: begin p = a; q = 4'h0; end
                4'd1: begin p = a | b; q = 4'h0; end
                4'd2: begin p = a | ~b; q = 4'h0; end
                4'd3: begin p = 4'h0; q = 4'hF; end
                4'd4: begin p = a; q = a & ~b; end
                4'd5: begin p = a | b; q = a & ~b; end
                4'd6: begin p = a; q = ~b; end
                4'd7: begin p = a & ~b; q = 4'hF; end
                4'd8: begin p = a; q = a & b; end
                4'd9: begin p = a; q = b; end
                4'd10: begin p = a | ~b; q = a & b; end
                4'd11: begin p = a & b; q = 4'hF; end
                4'd12: begin p = a; q = a; end
                4'd13: begin p = a | b; q = a; end
                4'd14: begin p = a | ~b; q = a; end
                default: begin p = a; q = 4'hF; end
            endcase
            r  = int'(p) + int'(q) + int'(ci);
            f  = r[3:0];
            co = (r > 15);
        end
        return {co, (f == 4'h0), f};
    endfunction

    task automatic alu_set(input logic [3:0] s, input logic m, input logic ci,
                           input logic [3:0] a, input logic [3:0] b);
        alu_s = s; alu_m = m; alu_crin = ci; alu_a = a; alu_b = b;
        #1;
    endtask

    initial begin
        rst = 1'b0; cnt_ld = 1'b0; cnt_inc = 1'b0; cnt_x = 16'h0000;
        c2_inc = 1'b0; c2_x = 2'b00; d2_x = 3'd0; dec_x = 3'd0;
        alu_s = 4'd0; alu_m = 1'b0; alu_crin = 1'b0; alu_a = 4'd0; alu_b = 4'd0;
        #2;
        check_eq("cnt_reset", 32'(cnt_y), 32'h0);
        check_eq("cnt2_reset", 32'(c2_y), 32'h0);

        tick();
        rst = 1'b1;
        cnt_ld = 1'b1; cnt_x = 16'h1234;
        tick();
        check_eq("cnt_load_1234", 32'(cnt_y), 32'h1234);
        cnt_ld = 1'b0;
        #2;
        rst = 1'b0;
        #1;
        check_eq("cnt_async_rst", 32'(cnt_y), 32'h0);
        cnt_inc = 1'b1;
        tick();
        check_eq("cnt_held_in_rst", 32'(cnt_y), 32'h0);
        rst = 1'b1;
        tick();
        check_eq("cnt_inc1", 32'(cnt_y), 32'h1);
        tick();
        check_eq("cnt_inc2", 32'(cnt_y), 32'h2);
        tick();
        check_eq("cnt_inc3", 32'(cnt_y), 32'h3);
        cnt_ld = 1'b1; cnt_x = 16'hBEEF;
        tick();
        check_eq("cnt_ld_wins", 32'(cnt_y), 32'hBEEF);
        cnt_ld = 1'b0; cnt_inc = 1'b0; cnt_x = 16'h0000;
        tick();
        check_eq("cnt_hold_a", 32'(cnt_y), 32'hBEEF);
        tick();
        check_eq("cnt_hold_b", 32'(cnt_y), 32'hBEEF);
        cnt_ld = 1'b1; cnt_x = 16'hFFFF;
        tick();
        check_eq("cnt_load_ffff", 32'(cnt_y), 32'hFFFF);
        cnt_ld = 1'b0; cnt_inc = 1'b1;
        tick();
        check_eq("cnt_wrap16", 32'(cnt_y), 32'h0);
        cnt_inc = 1'b0;

        c2_inc = 1'b1;
        tick(); check_eq("cnt2_e1", 32'(c2_y), 32'h1);
        tick(); check_eq("cnt2_e2", 32'(c2_y), 32'h2);
        tick(); check_eq("cnt2_e3", 32'(c2_y), 32'h3);
        tick(); check_eq("cnt2_wrap", 32'(c2_y), 32'h0);
        tick(); check_eq("cnt2_e5", 32'(c2_y), 32'h1);
        c2_inc = 1'b0;

        for (int i = 0; i < 8; i++) begin
            dec_x = 3'(i);
            #1;
            check_eq("dec_onehot", 32'(dec_y), 32'(1) << i);
            check_eq("dec_popcount", 32'($countones(dec_y)), 32'd1);
        end

        alu_set(4'd9, 1'b0, 1'b0, 4'd7, 4'd9);
        check_eq("add_7_9", 32'({alu_crout, alu_zero, alu_f}), 32'h30);
        alu_set(4'd6, 1'b0, 1'b1, 4'd5, 4'd3);
        check_eq("sub_5_3", 32'({alu_crout, alu_f}), 32'h12);
        alu_set(4'd6, 1'b0, 1'b1, 4'd3, 4'd5);
        check_eq("sub_3_5", 32'({alu_crout, alu_f}), 32'h0E);
        alu_set(4'd0, 1'b0, 1'b1, 4'hF, 4'h0);
        check_eq("inc_f", 32'({alu_crout, alu_f}), 32'h10);
        alu_set(4'd15, 1'b0, 1'b0, 4'h0, 4'h0);
        check_eq("dec_0", 32'({alu_crout, alu_f}), 32'h0F);
        alu_set(4'd3, 1'b0, 1'b0, 4'h5, 4'hA);
        check_eq("minus_one", 32'(alu_f), 32'hF);
        alu_set(4'd6, 1'b1, 1'b1, 4'hC, 4'hA);
        check_eq("log_xor", 32'({alu_crout, alu_f}), 32'h06);
        alu_set(4'd11, 1'b1, 1'b1, 4'hC, 4'hA);
        check_eq("log_and", 32'({alu_crout, alu_f}), 32'h08);
        alu_set(4'd14, 1'b1, 1'b0, 4'hC, 4'hA);
        check_eq("log_or", 32'({alu_crout, alu_f}), 32'h0E);
        alu_set(4'd0, 1'b1, 1'b1, 4'hC, 4'hA);
        check_eq("log_nota", 32'({alu_crout, alu_f}), 32'h03);
        alu_set(4'd3, 1'b1, 1'b1, 4'hC, 4'hA);
        check_eq("log_zero", 32'({alu_crout, alu_zero, alu_f}), 32'h10);

        for (int v = 0; v < 16384; v++) begin
            logic [13:0] vec;
            vec = 14'(v);
            alu_set(vec[13:10], vec[9], vec[8], vec[7:4], vec[3:0]);
            check_eq("alu_exh", 32'({alu_crout, alu_zero, alu_f}),
                     32'(alu_ref(vec[13:10], vec[9], vec[8], vec[7:4], vec[3:0])));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/slug_exec_primitives.md
Name: slug_exec_primitives

Overview:
- Bundles the three shared execution primitives of the 4-bit slug CPU:
  - a loadable up-counter, used for the phase and program counters;
  - a binary-to-one-hot decoder, used for phase and register select;
  - a 4-bit 74181-style ALU with an active-high data convention.
- The counter is the only state. The decoder and ALU are purely combinational and independent of clk/rst.

Parameters:
- CNT_WIDTH, 16, width of counter load value and count output.
- DEC_WIDTH, 3, decoder input width; output width is 2**DEC_WIDTH.

Ports:
- clk  input  1  counter clock, rising edge.
- rst  input  1  asynchronous active-low reset; clears the counter.
- cnt_ld  input  1  synchronous load enable.
- cnt_inc  input  1  synchronous increment enable.
- cnt_x  input  CNT_WIDTH  load value.
- cnt_y  output  CNT_WIDTH  current count.
- dec_x  input  DEC_WIDTH  binary select.
- dec_y  output  2**DEC_WIDTH  one-hot decode.
- alu_s  input  4  function select S3..S0.
- alu_m  input  1  mode: 1 = logic, 0 = arithmetic.
- alu_crin  input  1  carry in, active-high (1 adds one).
- alu_a  input  4  operand A.
- alu_b  input  4  operand B.
- alu_f  output  4  result.
- alu_crout  output  1  carry out, active-high.
- alu_zero  output  1  high when alu_f == 0.

Behaviour:

Counter:
- rst low: cnt_y = 0 immediately, independent of clk, and held while rst is low.
- On rising clk with rst high, priority is ld > inc > hold:
  - cnt_ld=1: cnt_y <= cnt_x, regardless of cnt_inc.
  - else cnt_inc=1: cnt_y <= cnt_y+1 modulo 2**CNT_WIDTH; all-ones wraps to 0 with no flag.
  - else: hold.
- Reset deasserting: the first rising edge with rst high acts normally.

Decoder:
- dec_y[i] = 1 iff dec_x == i; exactly one bit high at all times.

ALU, arithmetic mode (alu_m=0):
- Result = P + Q + alu_crin in 5 bits; alu_f = bits[3:0], alu_crout = bit 4.
- (P,Q) per alu_s; ~ is bitwise 4-bit:
  - 0: A, 0
  - 1: A|B, 0
  - 2: A|~B, 0
  - 3: 0, 1111
  - 4: A, A&~B
  - 5: A|B, A&~B
  - 6: A, ~B (A-B-1; with crin=1, A-B)
  - 7: A&~B, 1111
  - 8: A, A&B
  - 9: A, B
  - 10: A|~B, A&B
  - 11: A&B, 1111
  - 12: A, A
  - 13: A|B, A
  - 14: A|~B, A
  - 15: A, 1111 (A-1; with crin=1, A and crout=1)

ALU, logic mode (alu_m=1):
- alu_crout = 0; alu_crin ignored.
- alu_f per alu_s:
  - 0: ~A
  - 1: ~(A|B)
  - 2: ~A&B
  - 3: 0000
  - 4: ~(A&B)
  - 5: ~B
  - 6: A^B
  - 7: A&~B
  - 8: ~A|B
  - 9: ~(A^B)
  - 10: B
  - 11: A&B
  - 12: 1111
  - 13: A|~B
  - 14: A|B
  - 15: A

ALU, general:
- alu_zero = NOR of alu_f in both modes.
- ALU outputs settle combinationally in the same cycle; no latency.
- X-free for all 2^14 input combinations.

Test Plan:
- Counter basics (CNT_WIDTH=16): rst low mid-count with value 0x1234 -> cnt_y=0 before the next clk edge. Release rst, inc=1 for 3 edges -> 1, 2, 3. ld=1, inc=1, x=0xBEEF -> 0xBEEF (load wins). Both enables low -> holds 0xBEEF.
- Counter wrap: load 0xFFFF, inc -> 0x0000. CNT_WIDTH=2 instance, inc for 5 edges -> 1, 2, 3, 0, 1.
- Decoder: sweep dec_x 0..7 -> dec_y = 0x01, 0x02, ... 0x80. Exactly one bit set every step.
- ALU add/subtract:
  - s=9, m=0, crin=0, A=7, B=9 -> f=0, crout=1, zero=1.
  - s=6, crin=1, A=5, B=3 -> f=2, crout=1.
  - s=6, crin=1, A=3, B=5 -> f=0xE, crout=0.
- ALU increment/pass/-1:
  - s=0, crin=1, A=0xF -> f=0, crout=1.
  - s=15, crin=0, A=0 -> f=0xF, crout=0.
  - s=3, crin=0 -> f=0xF.
- ALU logic: m=1, A=0xC, B=0xA:
  - s=6 -> 6; s=11 -> 8; s=14 -> 0xE; s=0 -> 3; s=3 -> 0 with zero=1.
  - crout=0 throughout.
  - Exhaustively compare all modes against the tables above.
